// File: rtl/ploc_pkg.sv
// Shared types and constants for the parking-lot occupancy counter.
// Sensor codes are {a,b}: a = outer sensor, b = inner sensor.
package ploc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      A_ONLY,
      AB_IN,
      B_IN,
      B_ONLY,
      AB_OUT,
      A_OUT,
      FAULT
   } gate_state_e;

   localparam logic [1:0] S_NONE = 2'b00;
   localparam logic [1:0] S_A    = 2'b10;
   localparam logic [1:0] S_B    = 2'b01;
   localparam logic [1:0] S_AB   = 2'b11;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/ploc_gate_fsm.sv
// One gate: two-flop synchroniser, debounce filter and direction decoder.
// Emits registered one-cycle pulses only for complete, legal passages.
module ploc_gate_fsm
   import ploc_pkg::*;
#(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic sens_a,
   input  logic sens_b,
   output logic enter_evt,
   output logic exit_evt,
   output logic gate_err
);

   localparam int CW = clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] DEB_N = CW'(DEB_CYCLES);

   logic [1:0]    sync1, sync2, filt, cand;
   logic [CW-1:0] cnt, run;
   gate_state_e   state, state_nxt;
   logic          enter_nxt, exit_nxt, err_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= S_NONE;
         sync2 <= S_NONE;
      end else begin
         sync1 <= {sens_a, sens_b};
         sync2 <= sync1;
      end
   end

   // run = length of the current streak of an unchanged value that differs from filt
   always_comb run = (sync2 == cand && cnt != '0) ? cnt + CW'(1) : CW'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         filt <= S_NONE;
         cand <= S_NONE;
         cnt  <= '0;
      end else begin
         cand <= sync2;
         if (sync2 == filt) begin
            cnt <= '0;
         end else if (run >= DEB_N) begin
            filt <= sync2;
            cnt  <= '0;
         end else begin
            cnt <= run;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (filt == S_A)         state_nxt = A_ONLY;
                 else if (filt == S_B)    state_nxt = B_ONLY;
                 else if (filt == S_AB)   state_nxt = FAULT;
         A_ONLY: if (filt == S_AB)        state_nxt = AB_IN;
                 else if (filt == S_NONE) state_nxt = IDLE;
                 else if (filt == S_B)    state_nxt = FAULT;
         AB_IN:  if (filt == S_B)         state_nxt = B_IN;
                 else if (filt == S_A)    state_nxt = A_ONLY;
                 else if (filt == S_NONE) state_nxt = FAULT;
         B_IN:   if (filt == S_NONE)      state_nxt = IDLE;
                 else if (filt == S_AB)   state_nxt = AB_IN;
                 else if (filt == S_A)    state_nxt = FAULT;
         B_ONLY: if (filt == S_AB)        state_nxt = AB_OUT;
                 else if (filt == S_NONE) state_nxt = IDLE;
                 else if (filt == S_A)    state_nxt = FAULT;
         AB_OUT: if (filt == S_A)         state_nxt = A_OUT;
                 else if (filt == S_B)    state_nxt = B_ONLY;
                 else if (filt == S_NONE) state_nxt = FAULT;
         A_OUT:  if (filt == S_NONE)      state_nxt = IDLE;
                 else if (filt == S_AB)   state_nxt = AB_OUT;
                 else if (filt == S_B)    state_nxt = FAULT;
         FAULT:  if (filt == S_NONE)      state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      enter_nxt = (state == B_IN)  && (filt == S_NONE);
      exit_nxt  = (state == A_OUT) && (filt == S_NONE);
      err_nxt   = (state_nxt == FAULT) && (state != FAULT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         enter_evt <= 1'b0;
         exit_evt  <= 1'b0;
         gate_err  <= 1'b0;
      end else begin
         state     <= state_nxt;
         enter_evt <= enter_nxt;
         exit_evt  <= exit_nxt;
         gate_err  <= err_nxt;
      end
   end

endmodule

// File: rtl/ploc_multi_gate_counter.sv
// Parking-lot occupancy counter: per-gate decoders feeding a shared
// saturating occupancy accumulator with manual load and an error tally.
module ploc_multi_gate_counter
   import ploc_pkg::*;
#(
   parameter int NUM_GATES  = 2,
   parameter int COUNT_W    = 8,
   parameter int CAPACITY   = 200,
   parameter int DEB_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_GATES-1:0] sens_a,
   input  logic [NUM_GATES-1:0] sens_b,
   input  logic                 load,
   input  logic [COUNT_W-1:0]   load_val,
   output logic [COUNT_W-1:0]   occupancy,
   output logic                 full,
   output logic                 empty,
   output logic [NUM_GATES-1:0] enter_evt,
   output logic [NUM_GATES-1:0] exit_evt,
   output logic [NUM_GATES-1:0] gate_err,
   output logic                 reject,
   output logic [COUNT_W-1:0]   err_count
);

   localparam int NW = clog2(NUM_GATES + 1) + 1;
   localparam int SW = COUNT_W + NW;
   localparam logic [COUNT_W-1:0]   CAP   = COUNT_W'(CAPACITY);
   localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);

   for (genvar g = 0; g < NUM_GATES; g++) begin : gen_gate
      ploc_gate_fsm #(.DEB_CYCLES(DEB_CYCLES)) u_gate (
         .clk       (clk),
         .reset     (reset),
         .sens_a    (sens_a[g]),
         .sens_b    (sens_b[g]),
         .enter_evt (enter_evt[g]),
         .exit_evt  (exit_evt[g]),
         .gate_err  (gate_err[g])
      );
   end

   logic [NW-1:0]          n_in, n_out, n_err;
   logic signed [NW-1:0]   net;
   logic signed [SW-1:0]   sum;
   logic [SW-1:0]          err_sum;
   logic [COUNT_W-1:0]     load_c;

   always_comb begin
      n_in  = '0;
      n_out = '0;
      n_err = '0;
      for (int g = 0; g < NUM_GATES; g++) begin
         n_in  = n_in  + NW'(enter_evt[g]);
         n_out = n_out + NW'(exit_evt[g]);
         n_err = n_err + NW'(gate_err[g]);
      end
   end

   // Enters and exits cancel first, so only the true net can be clamped.
   assign net     = $signed(n_in) - $signed(n_out);
   assign sum     = $signed({{NW{1'b0}}, occupancy}) + SW'(net);
   assign err_sum = {{NW{1'b0}}, err_count} + SW'(n_err);
   assign load_c  = (load_val > CAP) ? CAP : load_val;

   always_ff @(posedge clk) begin
      if (reset) begin
         occupancy <= '0;
         err_count <= '0;
         reject    <= 1'b0;
      end else begin
         reject <= 1'b0;
         if (load) begin
            occupancy <= load_c;
         end else if (sum[SW-1]) begin
            occupancy <= '0;
            reject    <= 1'b1;
         end else if (sum > CAP_S) begin
            occupancy <= CAP;
            reject    <= 1'b1;
         end else begin
            occupancy <= sum[COUNT_W-1:0];
         end
         if (err_sum[SW-1:COUNT_W] != '0) err_count <= '1;
         else                             err_count <= err_sum[COUNT_W-1:0];
      end
   end

   assign full  = (occupancy == CAP);
   assign empty = (occupancy == '0);

endmodule
